// File: rtl/des_spi_ctrl.sv
// des_spi_ctrl: SPI-to-DES bridge that syncs cs_n, captures key/data frames, runs DES and hands back results.
//
// Ports:
//   clk, rst (async, active-low)    system clock and reset
//   cs_n, spi_text                  SPI frame strobe (async) and received 64-bit word
//   load_key, decrypt, err_clr      frame-type strap, direction strap, sticky error clear
//   des_start/key/din/decrypt       launch interface to the DES core
//   des_done, des_dout              completion pulse and result from the DES core
//   output_text                     result returned to the SPI slave for read-back
//   busy, key_valid, err[2:0]       status; err = {timeout, no-key, overrun}
module des_spi_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs_n,
    input  logic [63:0] spi_text,
    input  logic        load_key,
    input  logic        decrypt,
    input  logic        err_clr,
    output logic        des_start,
    output logic [63:0] des_key,
    output logic [63:0] des_din,
    output logic        des_decrypt,
    input  logic        des_done,
    input  logic [63:0] des_dout,
    output logic [63:0] output_text,
    output logic        busy,
    output logic        key_valid,
    output logic [2:0]  err
);
    typedef enum logic [1:0] {IDLE, READY, RUN} state_t;

    localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   dly_q, dly_d;
    logic [9:0]             cnt_q, cnt_d;
    logic [63:0]            key_q, key_d, din_q, din_d, out_q, out_d, pend_q, pend_d;
    logic                   dec_q, dec_d, start_q, start_d, busy_q, busy_d;
    logic                   kv_q, kv_d, pend_v_q, pend_v_d;
    logic [2:0]             err_q, err_d, err_set;
    logic                   cs_sync, frame_end;

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], cs_n};
        cs_sync   = sync_q[SYNC_STAGES-1];
        dly_d     = cs_sync;
        frame_end = cs_sync & ~dly_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        key_d     = key_q;
        din_d     = din_q;
        dec_d     = dec_q;
        start_d   = 1'b0;
        kv_d      = kv_q;
        out_d     = out_q;
        pend_d    = pend_q;
        pend_v_d  = pend_v_q;
        err_set   = 3'b000;
        if (frame_end) begin
            if (state_q == RUN) begin
                err_set[0] = 1'b1;
            end else if (load_key) begin
                key_d   = spi_text;
                kv_d    = 1'b1;
                state_d = READY;
            end else if (state_q == READY) begin
                din_d   = spi_text;
                dec_d   = decrypt;
                start_d = 1'b1;
                cnt_d   = '0;
                state_d = RUN;
            end else begin
                err_set[1] = 1'b1;
            end
        end
        // done takes priority over a timeout landing on the same edge
        if (state_q == RUN) begin
            cnt_d = cnt_q + 10'd1;
            if (des_done) begin
                state_d = READY;
            end else if (cnt_q == TO_LAST) begin
                err_set[2] = 1'b1;
                state_d    = READY;
            end
        end
        // output_text only moves while the SPI side is idle; otherwise park the result
        if (state_q == RUN && des_done) begin
            if (cs_sync) begin
                out_d    = des_dout;
                pend_v_d = 1'b0;
            end else begin
                pend_d   = des_dout;
                pend_v_d = 1'b1;
            end
        end else if (pend_v_q && cs_sync) begin
            out_d    = pend_q;
            pend_v_d = 1'b0;
        end
        err_d  = (err_clr ? 3'b000 : err_q) | err_set;
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            sync_q   <= '1;
            dly_q    <= 1'b1;
            cnt_q    <= '0;
            key_q    <= '0;
            din_q    <= '0;
            dec_q    <= 1'b0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            kv_q     <= 1'b0;
            out_q    <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            dly_q    <= dly_d;
            cnt_q    <= cnt_d;
            key_q    <= key_d;
            din_q    <= din_d;
            dec_q    <= dec_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            kv_q     <= kv_d;
            out_q    <= out_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            err_q    <= err_d;
        end
    end

    assign des_start   = start_q;
    assign des_key     = key_q;
    assign des_din     = din_q;
    assign des_decrypt = dec_q;
    assign output_text = out_q;
    assign busy        = busy_q;
    assign key_valid   = kv_q;
    assign err         = err_q;
endmodule

// File: tb/tb_des_spi_ctrl.sv
// tb_des_spi_ctrl: directed and randomized frame sequences checked against a frame-level model.
module tb_des_spi_ctrl;
    localparam int SS = 2;

    logic        clk = 1'b0;
    logic        rst_n, cs_n, load_key, decrypt, err_clr, des_done;
    logic [63:0] spi_text, des_dout;
    logic        des_start, des_decrypt, busy, key_valid;
    logic [63:0] des_key, des_din, output_text;
    logic [2:0]  err;

    int checks = 0, errors = 0, n_start = 0;
    logic [63:0] exp_key, exp_out, exp_din, t, r;
    int exp_starts, lat;
    logic d;

    des_spi_ctrl #(.SYNC_STAGES(SS), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst_n), .cs_n(cs_n), .spi_text(spi_text), .load_key(load_key),
        .decrypt(decrypt), .err_clr(err_clr), .des_start(des_start), .des_key(des_key),
        .des_din(des_din), .des_decrypt(des_decrypt), .des_done(des_done), .des_dout(des_dout),
        .output_text(output_text), .busy(busy), .key_valid(key_valid), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (des_start) n_start <= n_start + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns just after the edge that captures the frame.
    task automatic send_frame(input logic [63:0] text, input logic lk, input logic dec);
        cs_n = 1'b0;
        spi_text = text;
        load_key = lk;
        decrypt = dec;
        repeat (4) tick();
        cs_n = 1'b1;
        repeat (SS + 1) tick();
    endtask

    task automatic finish_run(input int cycles, input logic [63:0] res);
        repeat (cycles - 1) tick();
        des_dout = res;
        des_done = 1'b1;
        tick();
        des_done = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cs_n = 1'b1; spi_text = '0; load_key = 1'b0; decrypt = 1'b0;
        err_clr = 1'b0; des_done = 1'b0; des_dout = '0;
        repeat (3) tick();
        check("rst_start", des_start, 0);
        check("rst_busy", busy, 0);
        check("rst_kv", key_valid, 0);
        check("rst_key", des_key, 0);
        check("rst_out", output_text, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        tick();

        send_frame(64'hDEAD_BEEF_0000_1111, 1'b0, 1'b0);
        tick();
        check("nokey_starts", n_start, 0);
        check("nokey_err", err, 3'b010);
        check("nokey_din", des_din, 0);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("errclr", err, 0);

        exp_key = 64'h1334_5779_9BBC_DFF1;
        send_frame(exp_key, 1'b1, 1'b0);
        check("key_val", des_key, exp_key);
        check("key_kv", key_valid, 1);
        send_frame(64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
        check("run_start", des_start, 1);
        check("run_busy", busy, 1);
        check("run_din", des_din, 64'h0123_4567_89AB_CDEF);
        check("run_dec", des_decrypt, 0);
        tick();
        check("start_pulse", des_start, 0);
        repeat (13) tick();
        check("busy_15", busy, 1);
        des_dout = 64'h85E8_1354_0F0A_B405; des_done = 1'b1; tick(); des_done = 1'b0;
        check("done_busy", busy, 0);
        check("done_out", output_text, 64'h85E8_1354_0F0A_B405);
        check("done_err", err, 0);
        check("done_starts", n_start, 1);
        exp_out = 64'h85E8_1354_0F0A_B405;
        exp_starts = 1;

        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                exp_key = {$urandom, $urandom};
                send_frame(exp_key, 1'b1, 1'b0);
                check("rnd_key", des_key, exp_key);
            end
            t = {$urandom, $urandom};
            r = {$urandom, $urandom};
            d = 1'($urandom_range(0, 1));
            lat = $urandom_range(1, 50);
            send_frame(t, 1'b0, d);
            exp_starts++;
            check("rnd_busy", busy, 1);
            check("rnd_din", des_din, t);
            check("rnd_dec", des_decrypt, d);
            finish_run(lat, r);
            exp_out = r;
            check("rnd_out", output_text, exp_out);
            check("rnd_idle", busy, 0);
            check("rnd_keep", des_key, exp_key);
            check("rnd_starts", n_start, exp_starts);
        end
        check("rnd_err", err, 0);

        t = {$urandom, $urandom};
        send_frame(t, 1'b0, 1'b1);
        exp_starts++;
        repeat (5) tick();
        send_frame({$urandom, $urandom}, 1'b0, 1'b0);
        check("ovr_err", err, 3'b001);
        check("ovr_din", des_din, t);
        check("ovr_busy", busy, 1);
        r = {$urandom, $urandom};
        finish_run(8, r);
        exp_out = r;
        check("ovr_out", output_text, exp_out);
        check("ovr_starts", n_start, exp_starts);
        err_clr = 1'b1; tick(); err_clr = 1'b0;

        send_frame({$urandom, $urandom}, 1'b0, 1'b0);
        exp_starts++;
        repeat (63) tick();
        check("to_busy63", busy, 1);
        tick();
        check("to_busy64", busy, 0);
        check("to_err", err, 3'b100);
        check("to_out", output_text, exp_out);
        des_dout = {$urandom, $urandom}; des_done = 1'b1; tick(); des_done = 1'b0;
        check("late_out", output_text, exp_out);
        check("late_busy", busy, 0);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("to_clr", err, 0);

        send_frame({$urandom, $urandom}, 1'b0, 1'b0);
        exp_starts++;
        tick();
        cs_n = 1'b0;
        repeat (3) tick();
        r = {$urandom, $urandom};
        des_dout = r; des_done = 1'b1; tick(); des_done = 1'b0;
        check("hold_busy", busy, 0);
        check("hold_out0", output_text, exp_out);
        repeat (3) tick();
        check("hold_out1", output_text, exp_out);
        spi_text = exp_key; load_key = 1'b1; cs_n = 1'b1;
        repeat (SS) tick();
        check("hold_out2", output_text, exp_out);
        tick();
        exp_out = r;
        check("hold_xfer", output_text, exp_out);
        load_key = 1'b0;
        tick();

        send_frame({$urandom, $urandom}, 1'b0, 1'b0);
        exp_starts++;
        repeat (5) tick();
        #1 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_kv", key_valid, 0);
        check("arst_key", des_key, 0);
        check("arst_din", des_din, 0);
        check("arst_out", output_text, 0);
        tick();
        rst_n = 1'b1;
        tick();
        des_dout = {$urandom, $urandom}; des_done = 1'b1; tick(); des_done = 1'b0;
        check("arst_done_out", output_text, 0);
        check("arst_done_busy", busy, 0);
        check("arst_done_err", err, 0);
        check("arst_starts", n_start, exp_starts);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
